// File: rtl/dpot_wiper_ctrl.sv
// Digital potentiometer wiper controller: tracks a target tap and walks the wiper toward it
// one tap per step, with a rate-limit delay and a break-before-make gap on every move.
module dpot_wiper_ctrl #(
    parameter int unsigned TAP_BITS  = 4,
    parameter int unsigned RESET_TAP = 8,
    parameter int unsigned STEP_DIV  = 16,
    parameter int unsigned DEAD      = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     inc,
    input  logic                     dec,
    input  logic                     load,
    input  logic [TAP_BITS-1:0]      load_val,
    output logic [2**TAP_BITS-1:0]   tap_en,
    output logic [TAP_BITS-1:0]      wiper,
    output logic [TAP_BITS-1:0]      target,
    output logic                     busy
);

    localparam int unsigned NTAPS   = 2**TAP_BITS;
    localparam int unsigned CNT_MAX = (STEP_DIV > DEAD) ? STEP_DIV : DEAD;
    localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CW-1:0]       WAIT_LAST = CW'(STEP_DIV - 1);
    localparam logic [CW-1:0]       DEAD_LAST = CW'(DEAD - 1);
    localparam logic [TAP_BITS-1:0] TAP_RST   = TAP_BITS'(RESET_TAP);
    localparam logic [TAP_BITS-1:0] TAP_TOP   = '1;

    typedef enum logic [1:0] {StIdle, StWait, StBreak} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          dir_up;

    function automatic logic [NTAPS-1:0] onehot(input logic [TAP_BITS-1:0] pos);
        logic [NTAPS-1:0] v;
        v      = '0;
        v[pos] = 1'b1;
        return v;
    endfunction

    // Load wins over inc/dec; inc and dec together cancel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            target <= TAP_RST;
        end else if (load) begin
            target <= load_val;
        end else if (inc && !dec && target != TAP_TOP) begin
            target <= target + 1'b1;
        end else if (dec && !inc && target != '0) begin
            target <= target - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= StIdle;
            cnt    <= '0;
            dir_up <= 1'b0;
            wiper  <= TAP_RST;
            tap_en <= onehot(TAP_RST);
        end else begin
            case (state)
                StIdle: begin
                    if (target != wiper) begin
                        state <= StWait;
                        cnt   <= '0;
                    end
                end
                StWait: begin
                    if (cnt == WAIT_LAST) begin
                        cnt <= '0;
                        // Re-evaluate here: the target may have swung back onto the wiper.
                        if (target == wiper) begin
                            state <= StIdle;
                        end else begin
                            dir_up <= (target > wiper);
                            tap_en <= '0;
                            state  <= StBreak;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                StBreak: begin
                    if (cnt == DEAD_LAST) begin
                        cnt   <= '0;
                        state <= StIdle;
                        if (dir_up) begin
                            wiper  <= wiper + 1'b1;
                            tap_en <= onehot(wiper + 1'b1);
                        end else begin
                            wiper  <= wiper - 1'b1;
                            tap_en <= onehot(wiper - 1'b1);
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign busy = (state != StIdle) || (target != wiper);

endmodule

// File: tb/tb_dpot_wiper_ctrl.sv
// Bench for dpot_wiper_ctrl: timeline model checked every cycle plus directed literal checks.
module tb_dpot_wiper_ctrl;

    localparam int STEP_DIV = 16;
    localparam int DEAD     = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        inc, dec, load;
    logic [3:0]  load_val;
    logic [15:0] tap_en;
    logic [3:0]  wiper, target;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    dpot_wiper_ctrl #(
        .TAP_BITS (4),
        .RESET_TAP(8),
        .STEP_DIV (STEP_DIV),
        .DEAD     (DEAD)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc     (inc),
        .dec     (dec),
        .load    (load),
        .load_val(load_val),
        .tap_en  (tap_en),
        .wiper   (wiper),
        .target  (target),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Model: absolute edge numbers at which each step decides and completes.
    int cyc = 0;
    int m_tgt = 8, m_wip = 8;
    bit m_pend = 0, m_brk = 0, m_up = 0;
    int m_dec_at = 0, m_done_at = 0;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_tgt = 8; m_wip = 8; m_pend = 0; m_brk = 0;
            end else begin
                cyc++;
                if (!m_pend) begin
                    if (m_tgt != m_wip) begin
                        m_pend   = 1;
                        m_dec_at = cyc + STEP_DIV;
                    end
                end else if (!m_brk) begin
                    if (cyc == m_dec_at) begin
                        if (m_tgt == m_wip) m_pend = 0;
                        else begin
                            m_up      = (m_tgt > m_wip);
                            m_brk     = 1;
                            m_done_at = cyc + DEAD;
                        end
                    end
                end else if (cyc == m_done_at) begin
                    m_wip  = m_up ? m_wip + 1 : m_wip - 1;
                    m_pend = 0;
                    m_brk  = 0;
                end
                if (load) m_tgt = int'(load_val);
                else if (inc && !dec) m_tgt = (m_tgt < 15) ? m_tgt + 1 : 15;
                else if (dec && !inc) m_tgt = (m_tgt > 0) ? m_tgt - 1 : 0;
            end
        end
    end

    logic [15:0] prev_tap = 16'h0;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_tap = 16'h0;
            end else begin
                logic [15:0] e_tap;
                e_tap = m_brk ? 16'h0 : (16'h1 << m_wip);
                check("model_tap_en", tap_en, e_tap);
                check("model_wiper", wiper, m_wip[3:0]);
                check("model_target", target, m_tgt[3:0]);
                check("model_busy", busy, (m_pend || m_tgt != m_wip));
                check("onehot_or_zero", ($countones(tap_en) <= 1), 1);
                check("no_make_before_break",
                      (prev_tap == 16'h0 || tap_en == 16'h0 || tap_en == prev_tap), 1);
                prev_tap = tap_en;
            end
        end
    end

    task automatic pulse(input logic i, input logic d, input logic l, input logic [3:0] v);
        @(negedge clk);
        inc = i; dec = d; load = l; load_val = v;
        @(negedge clk);
        inc = 0; dec = 0; load = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic wait_idle(input int limit);
        int k = 0;
        while (busy !== 1'b0 && k < limit) begin
            @(negedge clk);
            k++;
        end
        check("idle_within_budget", (k < limit), 1);
    endtask

    task automatic check_reset_vals(input string nm);
        check({nm, "_tap_en"}, tap_en, 16'h0100);
        check({nm, "_wiper"}, wiper, 4'd8);
        check({nm, "_target"}, target, 4'd8);
        check({nm, "_busy"}, busy, 1'b0);
    endtask

    initial begin
        int zeros;
        logic [15:0] e;
        rst_n = 0; inc = 0; dec = 0; load = 0; load_val = 0;
        repeat (3) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        check_reset_vals("reset");
        repeat (50) @(negedge clk);
        check_reset_vals("reset_hold");

        // Single inc: 17 cycles on tap 8, 2 dark cycles, then tap 9.
        pulse(1, 0, 0, 0);
        check("inc_target", target, 4'd9);
        check("inc_busy", busy, 1'b1);
        for (int i = 0; i <= 19; i++) begin
            if (i > 0) @(negedge clk);
            e = (i <= 16) ? 16'h0100 : (i <= 18) ? 16'h0000 : 16'h0200;
            check("inc_tap_seq", tap_en, e);
        end
        check("inc_wiper", wiper, 4'd9);
        check("inc_busy_done", busy, 1'b0);

        // Load 3 from 8: five steps of 19 cycles each.
        do_reset();
        pulse(0, 0, 1, 4'd3);
        zeros = 0;
        for (int i = 0; i <= 95; i++) begin
            if (i > 0) @(negedge clk);
            if (tap_en == 16'h0) zeros++;
            if (i == 94) begin
                check("load3_last_break", tap_en, 16'h0000);
                check("load3_wiper_94", wiper, 4'd4);
            end
        end
        check("load3_tap", tap_en, 16'h0008);
        check("load3_wiper", wiper, 4'd3);
        check("load3_busy", busy, 1'b0);
        check("load3_dark_cycles", zeros, 10);
        check("model_pin_wip", m_wip, 3);

        // Saturation and priority.
        pulse(0, 0, 1, 4'd15);
        repeat (3) pulse(1, 0, 0, 0);
        check("sat_top", target, 4'd15);
        pulse(1, 1, 0, 0);
        check("inc_dec_cancel", target, 4'd15);
        pulse(1, 0, 1, 4'd5);
        check("load_beats_inc", target, 4'd5);
        wait_idle(1000);
        check("settle_wiper", wiper, 4'd5);
        check("model_pin_tgt", m_tgt, 5);

        // Reversal during WAIT: step cancelled, no break.
        do_reset();
        pulse(1, 0, 0, 0);
        repeat (5) @(negedge clk);
        pulse(0, 1, 0, 0);
        check("rev_target", target, 4'd8);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            check("rev_tap_steady", tap_en, 16'h0100);
        end
        check("rev_busy", busy, 1'b0);

        // Asynchronous reset during BREAK.
        do_reset();
        pulse(1, 0, 0, 0);
        repeat (17) @(negedge clk);
        check("pre_reset_break", tap_en, 16'h0000);
        #2;
        rst_n = 0;
        #1;
        check_reset_vals("async_reset");
        @(negedge clk);
        rst_n = 1;
        repeat (3) @(negedge clk);
        check_reset_vals("post_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
